// File: rtl/sram_uart_pkg.sv
// Shared definitions for the SRAM-over-UART command protocol (host and controller side).
package sram_uart_pkg;

  localparam int unsigned CMD_WRITE_BIT = 7;
  localparam int unsigned CMD_ADDR_LSB  = 0;
  localparam int unsigned CMD_ADDR_W    = 5;
  localparam logic [7:0]  ACK_BYTE      = 8'hAC;

  typedef logic [2:0] host_state_t;

  localparam host_state_t ST_IDLE      = 3'd0;
  localparam host_state_t ST_SEND_CMD  = 3'd1;
  localparam host_state_t ST_SEND_DATA = 3'd2;
  localparam host_state_t ST_WAIT_RSP  = 3'd3;
  localparam host_state_t ST_RESP      = 3'd4;

  // Command byte: write flag in bit 7, word address in the low bits, rest zero.
  function automatic logic [7:0] build_cmd(input logic write,
                                           input logic [CMD_ADDR_W-1:0] addr);
    logic [7:0] cmd;
    cmd = '0;
    cmd[CMD_WRITE_BIT] = write;
    cmd[CMD_ADDR_LSB +: CMD_ADDR_W] = addr;
    return cmd;
  endfunction

endpackage

// File: rtl/sram_uart_host_timer.sv
// Response-gap watchdog: reloads on clear, counts down while running, flags expiry at zero.
module sram_uart_host_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_run,
  output logic o_expired_c
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Down-counter; holds at zero so it never wraps before the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= LOAD_VAL;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expired_c = i_run && (r_cnt == '0);

endmodule

// File: rtl/sram_uart_host.sv
// Host initiator: serializes read/write requests over a UART byte link and collects the reply.
module sram_uart_host
  import sram_uart_pkg::*;
#(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              rsp_timeout,
  output logic              tx_enable,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              rx_enable,
  output logic              rx_ready,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_error
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  host_state_t       r_state, w_nxt_state;
  logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
  logic              r_write, w_nxt_write;
  logic [DATA_W-1:0] r_wsh, w_nxt_wsh;
  logic [DATA_W-1:0] r_rsh, w_nxt_rsh;
  logic              r_req_ready, w_nxt_req_ready;
  logic              r_rsp_valid, w_nxt_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata, w_nxt_rsp_rdata;
  logic              r_rsp_error, w_nxt_rsp_error;
  logic              r_rsp_timeout, w_nxt_rsp_timeout;
  logic              r_tx_valid, w_nxt_tx_valid;
  logic [7:0]        r_tx_data, w_nxt_tx_data;
  logic              r_rx_ready, w_nxt_rx_ready;
  logic              r_en;

  logic              w_tx_fire;
  logic              w_rx_fire;
  logic              w_expired_c;
  logic [DATA_W-1:0] w_rsh_shift;

  assign w_tx_fire   = r_tx_valid && tx_ready;
  assign w_rx_fire   = r_rx_ready && rx_valid;
  assign w_rsh_shift = (r_rsh << 8) | DATA_W'(rx_data);

  // Gap timer restarts outside WAIT_RSP and on every accepted response byte.
  sram_uart_host_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     ((r_state != ST_WAIT_RSP) || w_rx_fire),
    .i_run      (r_state == ST_WAIT_RSP),
    .o_expired_c(w_expired_c)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_cnt         = r_cnt;
    w_nxt_write       = r_write;
    w_nxt_wsh         = r_wsh;
    w_nxt_rsh         = r_rsh;
    w_nxt_req_ready   = 1'b0;
    w_nxt_rsp_valid   = 1'b0;
    w_nxt_rsp_rdata   = '0;
    w_nxt_rsp_error   = 1'b0;
    w_nxt_rsp_timeout = 1'b0;
    w_nxt_tx_valid    = r_tx_valid;
    w_nxt_tx_data     = r_tx_data;
    w_nxt_rx_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_nxt_state    = ST_SEND_CMD;
          w_nxt_write    = req_write;
          w_nxt_wsh      = req_wdata;
          w_nxt_rsh      = '0;
          w_nxt_cnt      = '0;
          w_nxt_tx_valid = 1'b1;
          w_nxt_tx_data  = build_cmd(req_write, CMD_ADDR_W'(req_addr));
        end else begin
          w_nxt_req_ready = 1'b1;
        end
      end
      ST_SEND_CMD: begin
        if (w_tx_fire) begin
          if (r_write) begin
            w_nxt_state   = ST_SEND_DATA;
            w_nxt_tx_data = r_wsh[DATA_W-1 -: 8];
            w_nxt_wsh     = r_wsh << 8;
          end else begin
            w_nxt_state    = ST_WAIT_RSP;
            w_nxt_tx_valid = 1'b0;
            w_nxt_rx_ready = 1'b1;
          end
        end
      end
      ST_SEND_DATA: begin
        if (w_tx_fire) begin
          if (r_cnt == LAST_CNT) begin
            w_nxt_state    = ST_WAIT_RSP;
            w_nxt_tx_valid = 1'b0;
            w_nxt_rx_ready = 1'b1;
            w_nxt_cnt      = '0;
          end else begin
            w_nxt_cnt     = r_cnt + CNT_W'(1);
            w_nxt_tx_data = r_wsh[DATA_W-1 -: 8];
            w_nxt_wsh     = r_wsh << 8;
          end
        end
      end
      ST_WAIT_RSP: begin
        w_nxt_rx_ready = 1'b1;
        if (rx_error) begin
          w_nxt_state     = ST_RESP;
          w_nxt_rx_ready  = 1'b0;
          w_nxt_rsp_valid = 1'b1;
          w_nxt_rsp_error = 1'b1;
        end else if (w_rx_fire) begin
          if (r_write) begin
            w_nxt_state     = ST_RESP;
            w_nxt_rx_ready  = 1'b0;
            w_nxt_rsp_valid = 1'b1;
            w_nxt_rsp_error = (rx_data != ACK_BYTE);
          end else begin
            w_nxt_rsh = w_rsh_shift;
            w_nxt_cnt = r_cnt + CNT_W'(1);
            if (r_cnt == LAST_CNT) begin
              w_nxt_state     = ST_RESP;
              w_nxt_rx_ready  = 1'b0;
              w_nxt_rsp_valid = 1'b1;
              w_nxt_rsp_rdata = w_rsh_shift;
            end
          end
        end else if (w_expired_c) begin
          w_nxt_state       = ST_RESP;
          w_nxt_rx_ready    = 1'b0;
          w_nxt_rsp_valid   = 1'b1;
          w_nxt_rsp_timeout = 1'b1;
        end
      end
      ST_RESP: begin
        w_nxt_state     = ST_IDLE;
        w_nxt_req_ready = 1'b1;
      end
      default: begin
        w_nxt_state    = ST_IDLE;
        w_nxt_tx_valid = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_write       <= 1'b0;
      r_wsh         <= '0;
      r_rsh         <= '0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= '0;
      r_rx_ready    <= 1'b0;
      r_en          <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_cnt         <= w_nxt_cnt;
      r_write       <= w_nxt_write;
      r_wsh         <= w_nxt_wsh;
      r_rsh         <= w_nxt_rsh;
      r_req_ready   <= w_nxt_req_ready;
      r_rsp_valid   <= w_nxt_rsp_valid;
      r_rsp_rdata   <= w_nxt_rsp_rdata;
      r_rsp_error   <= w_nxt_rsp_error;
      r_rsp_timeout <= w_nxt_rsp_timeout;
      r_tx_valid    <= w_nxt_tx_valid;
      r_tx_data     <= w_nxt_tx_data;
      r_rx_ready    <= w_nxt_rx_ready;
      r_en          <= 1'b1;
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_error   = r_rsp_error;
  assign rsp_timeout = r_rsp_timeout;
  assign tx_enable   = r_en;
  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_tx_data;
  assign rx_enable   = r_en;
  assign rx_ready    = r_rx_ready;

endmodule

// File: tb/tb_sram_uart_host.sv
// Directed self-checking bench for sram_uart_host with a shortened response timeout.
module tb_sram_uart_host;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        tx_enable;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_enable;
  logic        rx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_error;

  int total = 0;
  int bad   = 0;
  logic [7:0] tx_got [0:7];

  sram_uart_host #(
    .ADDR_W(5),
    .DATA_W(32),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout),
    .tx_enable(tx_enable), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_enable(rx_enable), .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [4:0] addr, input logic [31:0] wd);
    int g;
    g = 0;
    while (req_ready !== 1'b1 && g < 50) begin
      tick();
      g++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
    chk("first_tx_valid", 32'(tx_valid), 32'd1);
  endtask

  task automatic drain_tx(input int n, input bit rnd);
    int   got;
    int   guard;
    logic held;
    logic [7:0] hold_d;
    got = 0; guard = 0; held = 1'b0; hold_d = '0;
    while (got < n && guard < 200) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) begin
        chk("tx_valid_stable", 32'(tx_valid), 32'd1);
        chk("tx_data_stable", 32'(tx_data), 32'(hold_d));
      end
      if (tx_valid && tx_ready) begin
        tx_got[got] = tx_data;
        got++;
        held = 1'b0;
      end else if (tx_valid) begin
        held   = 1'b1;
        hold_d = tx_data;
      end
      tick();
      guard++;
    end
    tx_ready = 1'b1;
    if (guard >= 200) chk("tx_byte_budget", 32'(got), 32'(n));
  endtask

  task automatic send_rx(input logic [7:0] b);
    chk("rx_ready_in_wait", 32'(rx_ready), 32'd1);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] rd, input logic e, input logic t);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, rd);
    chk({tag, "_error"}, 32'(rsp_error), 32'(e));
    chk({tag, "_timeout"}, 32'(rsp_timeout), 32'(t));
  endtask

  task automatic chk_after_rsp(input string tag);
    tick();
    chk({tag, "_pulse_end"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_error = 1'b0;
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_tx_enable", 32'(tx_enable), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("en_tx", 32'(tx_enable), 32'd1);
    chk("en_rx", 32'(rx_enable), 32'd1);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Bytes offered while idle must not be taken.
    rx_valid = 1'b1; rx_data = 8'h99;
    tick();
    chk("idle_rx_ready", 32'(rx_ready), 32'd0);
    rx_valid = 1'b0;

    // Write with good ACK.
    issue(1'b1, 5'h03, 32'hDEADBEEF);
    drain_tx(5, 1'b0);
    chk("w1_b0", 32'(tx_got[0]), 32'h83);
    chk("w1_b1", 32'(tx_got[1]), 32'hDE);
    chk("w1_b2", 32'(tx_got[2]), 32'hAD);
    chk("w1_b3", 32'(tx_got[3]), 32'hBE);
    chk("w1_b4", 32'(tx_got[4]), 32'hEF);
    chk("w1_no_tx_in_wait", 32'(tx_valid), 32'd0);
    send_rx(8'hAC);
    chk_rsp("w1", 32'h0, 1'b0, 1'b0);
    chk_after_rsp("w1");

    // Read of the top address.
    issue(1'b0, 5'h1F, 32'h0);
    drain_tx(1, 1'b0);
    chk("r1_cmd", 32'(tx_got[0]), 32'h1F);
    send_rx(8'h12); send_rx(8'h34); send_rx(8'h56);
    chk("r1_not_early", 32'(rsp_valid), 32'd0);
    send_rx(8'h78);
    chk_rsp("r1", 32'h12345678, 1'b0, 1'b0);
    chk_after_rsp("r1");

    // Write with a bad ACK byte.
    issue(1'b1, 5'h0A, 32'h01020304);
    drain_tx(5, 1'b0);
    chk("w2_cmd", 32'(tx_got[0]), 32'h8A);
    chk("w2_b4", 32'(tx_got[4]), 32'h04);
    send_rx(8'h55);
    chk_rsp("w2", 32'h0, 1'b1, 1'b0);
    chk_after_rsp("w2");

    // Read that stalls after two bytes times out 64 cycles later.
    issue(1'b0, 5'h07, 32'h0);
    drain_tx(1, 1'b0);
    chk("r2_cmd", 32'(tx_got[0]), 32'h07);
    send_rx(8'hAA); send_rx(8'hBB);
    k = 0;
    do begin
      tick();
      k++;
    end while (rsp_valid !== 1'b1 && k < 200);
    chk("r2_timeout_cycles", 32'(k), 32'd64);
    chk_rsp("r2", 32'h0, 1'b0, 1'b1);
    chk_after_rsp("r2");

    // Receiver frame error aborts a read.
    issue(1'b0, 5'h04, 32'h0);
    drain_tx(1, 1'b0);
    send_rx(8'h11);
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    chk_rsp("r3", 32'h0, 1'b1, 1'b0);
    chk_after_rsp("r3");

    // Write with a randomly stalling transmitter.
    issue(1'b1, 5'h15, 32'hCAFEF00D);
    drain_tx(5, 1'b1);
    chk("w3_b0", 32'(tx_got[0]), 32'h95);
    chk("w3_b1", 32'(tx_got[1]), 32'hCA);
    chk("w3_b2", 32'(tx_got[2]), 32'hFE);
    chk("w3_b3", 32'(tx_got[3]), 32'hF0);
    chk("w3_b4", 32'(tx_got[4]), 32'h0D);
    send_rx(8'hAC);
    chk_rsp("w3", 32'h0, 1'b0, 1'b0);
    chk_after_rsp("w3");

    // Reset in the middle of SEND_DATA, then a clean read.
    issue(1'b1, 5'h01, 32'h11223344);
    drain_tx(2, 1'b0);
    chk("w4_mid_tx_valid", 32'(tx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_tx_valid", 32'(tx_valid), 32'd0);
    chk("mr_tx_data", 32'(tx_data), 32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd0);
    chk("mr_rx_ready", 32'(rx_ready), 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_tx_enable", 32'(tx_enable), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mr_req_ready_after", 32'(req_ready), 32'd1);
    issue(1'b0, 5'h02, 32'h0);
    drain_tx(1, 1'b0);
    chk("r4_cmd", 32'(tx_got[0]), 32'h02);
    chk("r4_no_stale_tx", 32'(tx_valid), 32'd0);
    send_rx(8'hA5); send_rx(8'h5A); send_rx(8'h0F); send_rx(8'hF0);
    chk_rsp("r4", 32'hA55A0FF0, 1'b0, 1'b0);
    chk_after_rsp("r4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
